alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_arbiter_rr.sv | 35 +++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: operand/result words, opcodes, ALU command,
// requester index and arbiter FSM state.
package alu_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_REQ_MAX = 8;

    typedef logic [DATA_W-1:0] uint_t;

    typedef struct packed {
        logic  vld;
        uint_t data;
    } uint_vld_t;

    typedef enum logic [2:0] {
        OP_ADD       = 3'd0,
        OP_SUB       = 3'd1,
        OP_AND       = 3'd2,
        OP_OR        = 3'd3,
        OP_XOR       = 3'd4,
        OP_MUL       = 3'd5,
        OP_MUL_ACCUM = 3'd6
    } opcode_t;

    typedef struct packed {
        logic    vld;
        opcode_t op;
    } alu_cmd_t;

    typedef logic [2:0] req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } alu_arb_state_t;

    // Round-robin successor of a granted index, wrapping at n-1.
    function automatic req_id_t next_ptr(input req_id_t idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping to 0.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Upper segment [ptr, NUM_REQ-1] has priority over the wrapped segment.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && req[j] && (j >= int'(ptr))) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = req_id_t'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && req[j] && (j < int'(ptr))) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = req_id_t'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: accept, issue, respond.
// Optional accumulate-lock feature is built when ALU_ARB_LOCK_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic    [NUM_REQ-1:0]    req_vld,
    output logic    [NUM_REQ-1:0]    req_rdy,
    input  opcode_t [NUM_REQ-1:0]    req_op,
    input  uint_t   [NUM_REQ-1:0]    req_a,
    input  uint_t   [NUM_REQ-1:0]    req_b,
    input  logic    [NUM_REQ-1:0]    req_lock,
    output alu_cmd_t                 alu_cmd,
    output uint_vld_t                operand_a,
    output uint_vld_t                operand_b,
    input  uint_vld_t                result,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output req_id_t                  rsp_id,
    output uint_t                    rsp_data,
    output logic                     rsp_err
);

    alu_arb_state_t     state, next_state;
    req_id_t            rr_ptr;
    opcode_t            op_q;
    uint_t              a_q, b_q, rsp_data_q;
    req_id_t            id_q;
    logic               rsp_err_q;
    logic [NUM_REQ-1:0] eligible, grant;
    req_id_t            grant_idx;
    logic               grant_any;
    logic               accept;

`ifdef ALU_ARB_LOCK_EN
    logic               lock_active;
    req_id_t            lock_owner;
    logic [NUM_REQ-1:0] owner_mask;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_mask[i] = (req_id_t'(i) == lock_owner);
        end
        eligible = lock_active ? (req_vld & owner_mask) : req_vld;
    end

    // The lock follows the req_lock bit of whichever request the owner last had accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (accept) begin
            lock_active <= |(grant & req_lock);
            lock_owner  <= grant_idx;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign eligible    = req_vld;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign accept = (state == ST_IDLE) && grant_any;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (grant_any) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_RESP;
            ST_RESP:  if (rsp_rdy) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy        = (state == ST_IDLE) ? grant : '0;
        alu_cmd.vld    = (state == ST_ISSUE);
        alu_cmd.op     = op_q;
        operand_a.vld  = (state == ST_ISSUE);
        operand_a.data = a_q;
        operand_b.vld  = (state == ST_ISSUE);
        operand_b.data = b_q;
        rsp_vld        = (state == ST_RESP);
        rsp_id         = id_q;
        rsp_data       = rsp_data_q;
        rsp_err        = rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                id_q   <= grant_idx;
                rr_ptr <= next_ptr(grant_idx, NUM_REQ);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        op_q <= req_op[i];
                        a_q  <= req_a[i];
                        b_q  <= req_b[i];
                    end
                end
            end
            if (state == ST_ISSUE) begin
                rsp_data_q <= result.data;
                rsp_err_q  <= !result.vld;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests, expected grants/responses queued
// by the driver and checked by an independent monitor.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic    [N-1:0]   req_vld, req_rdy, req_lock;
    opcode_t [N-1:0]   req_op;
    uint_t   [N-1:0]   req_a, req_b;
    alu_cmd_t          alu_cmd;
    uint_vld_t         operand_a, operand_b, result;
    logic              rsp_vld, rsp_rdy, rsp_err;
    req_id_t           rsp_id;
    uint_t             rsp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        req_id_t id;
        uint_t   data;
        logic    err;
    } rsp_t;

    rsp_t         exp_rsp[$];
    int           exp_grant[$];
    logic [N-1:0] acc, sticky;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_lock  (req_lock),
        .alu_cmd   (alu_cmd),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU; unknown opcodes answer vld=0 with a marker word.
    always_comb begin
        result.vld  = 1'b0;
        result.data = 16'hBAD0;
        if (alu_cmd.vld) begin
            case (alu_cmd.op)
                OP_ADD:       begin result.vld = 1'b1; result.data = operand_a.data + operand_b.data; end
                OP_SUB:       begin result.vld = 1'b1; result.data = operand_a.data - operand_b.data; end
                OP_AND:       begin result.vld = 1'b1; result.data = operand_a.data & operand_b.data; end
                OP_OR:        begin result.vld = 1'b1; result.data = operand_a.data | operand_b.data; end
                OP_XOR:       begin result.vld = 1'b1; result.data = operand_a.data ^ operand_b.data; end
                OP_MUL:       begin result.vld = 1'b1; result.data = operand_a.data * operand_b.data; end
                OP_MUL_ACCUM: begin result.vld = 1'b1; result.data = operand_a.data * operand_b.data; end
                default:      begin result.vld = 1'b0; result.data = 16'hBAD0; end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT grants or completes a response.
    always @(negedge clk) begin
        if (!reset) begin
            if (req_rdy != '0) begin
                check("rdy_onehot", 32'($onehot(req_rdy)), 32'd1);
                if (exp_grant.size() == 0) begin
                    check("grant_unexpected", 32'(req_rdy), 32'd0);
                end else begin
                    int g;
                    g = exp_grant.pop_front();
                    check("grant_idx", 32'(req_rdy), 32'(1 << g));
                end
            end
            if (rsp_vld && rsp_rdy) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected_id", 32'(rsp_id), 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
        req_vld = req_vld & ~(acc & ~sticky);
    endtask

    task automatic mid();
        @(negedge clk);
        acc = req_rdy & req_vld;
    endtask

    task automatic cycle();
        edge_step();
        mid();
    endtask

    task automatic set_req(input int i, input opcode_t op, input uint_t a, input uint_t b, input logic lk);
        req_op[i]   = op;
        req_a[i]    = a;
        req_b[i]    = b;
        req_lock[i] = lk;
        req_vld[i]  = 1'b1;
    endtask

    task automatic push_rsp(input int id, input int data, input logic err);
        rsp_t r;
        r.id   = req_id_t'(id);
        r.data = uint_t'(data);
        r.err  = err;
        exp_rsp.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int gc[$];
        uint_t hold_data;
        req_vld  = '0;
        req_lock = '0;
        req_a    = '0;
        req_b    = '0;
        for (int i = 0; i < N; i++) req_op[i] = OP_ADD;
        rsp_rdy  = 1'b1;
        acc      = '0;
        sticky   = '0;
        reset    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        mid();
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_cmd_vld", 32'(alu_cmd.vld), 32'd0);
        check("rst_opa_vld", 32'(operand_a.vld), 32'd0);
        check("rst_opb_vld", 32'(operand_b.vld), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        edge_step();
        reset = 1'b0;
        mid();

        // Single request, latency T / T+1 / T+2
        edge_step();
        set_req(2, OP_ADD, 16'd5, 16'd7, 1'b0);
        exp_grant.push_back(2);
        push_rsp(2, 12, 1'b0);
        mid();
        check("t1_rdy_T", 32'(req_rdy), 32'b0100);
        cycle();
        check("t1_cmd_vld_T1", 32'(alu_cmd.vld), 32'd1);
        check("t1_cmd_op", 32'(alu_cmd.op), 32'(OP_ADD));
        check("t1_opa", 32'(operand_a.data), 32'd5);
        check("t1_opb", 32'(operand_b.data), 32'd7);
        check("t1_rdy_issue", 32'(req_rdy), 32'd0);
        check("t1_rsp_vld_T1", 32'(rsp_vld), 32'd0);
        cycle();
        check("t1_rsp_vld_T2", 32'(rsp_vld), 32'd1);
        check("t1_cmd_vld_T2", 32'(alu_cmd.vld), 32'd0);
        cycle();
        check("t1_rsp_vld_done", 32'(rsp_vld), 32'd0);

        // Round-robin with all four requesting from rr_ptr=0
        edge_step();
        reset = 1'b1;
        mid();
        edge_step();
        reset = 1'b0;
        mid();
        edge_step();
        for (int i = 0; i < N; i++) set_req(i, OP_ADD, uint_t'(i * 10), 16'd1, 1'b0);
        sticky = '1;
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        exp_grant.push_back(3); exp_grant.push_back(0);
        push_rsp(0, 1, 1'b0); push_rsp(1, 11, 1'b0); push_rsp(2, 21, 1'b0);
        push_rsp(3, 31, 1'b0); push_rsp(0, 1, 1'b0);
        mid();
        if (req_rdy != '0) gc.push_back(0);
        for (int k = 1; k < 15; k++) begin
            cycle();
            if (req_rdy != '0) gc.push_back(k);
        end
        check("rr_grant_count", 32'(gc.size()), 32'd5);
        for (int i = 0; i < gc.size(); i++) check("rr_grant_cycle", 32'(gc[i]), 32'(3 * i));
        edge_step();
        req_vld = '0;
        sticky  = '0;
        mid();
        check("rr_idle_rdy", 32'(req_rdy), 32'd0);

        // Backpressure: rr_ptr=1, requester 3 wins, held 10 cycles with 0 pending
        edge_step();
        rsp_rdy = 1'b0;
        set_req(3, OP_SUB, 16'd20, 16'd5, 1'b0);
        exp_grant.push_back(3);
        push_rsp(3, 15, 1'b0);
        exp_grant.push_back(0);
        push_rsp(0, 2, 1'b0);
        mid();
        cycle();
        edge_step();
        set_req(0, OP_ADD, 16'd1, 16'd1, 1'b0);
        mid();
        check("bp_rsp_vld0", 32'(rsp_vld), 32'd1);
        hold_data = rsp_data;
        check("bp_rsp_data0", 32'(hold_data), 32'd15);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("bp_rsp_vld", 32'(rsp_vld), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd3);
            check("bp_rsp_data", 32'(rsp_data), 32'd15);
            check("bp_rsp_err", 32'(rsp_err), 32'd0);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
            check("bp_cmd_vld", 32'(alu_cmd.vld), 32'd0);
        end
        edge_step();
        rsp_rdy = 1'b1;
        mid();
        cycle();
        check("bp_next_grant", 32'(req_rdy), 32'b0001);
        repeat (3) cycle();

        // Unknown opcode from requester 1 (rr_ptr=1)
        edge_step();
        set_req(1, opcode_t'(3'd7), 16'd3, 16'd4, 1'b0);
        exp_grant.push_back(1);
        push_rsp(1, 16'hBAD0, 1'b1);
        mid();
        cycle();
        check("badop_fwd", 32'(alu_cmd.op), 32'd7);
        cycle();
        check("badop_rsp_err", 32'(rsp_err), 32'd1);
        check("badop_rsp_id", 32'(rsp_id), 32'd1);
        cycle();

        // Reset during ISSUE abandons the transaction and clears rr_ptr
        edge_step();
        set_req(2, OP_ADD, 16'd1, 16'd1, 1'b0);
        exp_grant.push_back(2);
        mid();
        cycle();
        check("rst_iss_cmd_vld", 32'(alu_cmd.vld), 32'd1);
        #1 reset = 1'b1;
        edge_step();
        reset = 1'b0;
        mid();
        check("rst_iss_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_iss_cmd_vld0", 32'(alu_cmd.vld), 32'd0);
        check("rst_iss_req_rdy", 32'(req_rdy), 32'd0);
        edge_step();
        set_req(1, OP_ADD, 16'd100, 16'd1, 1'b0);
        set_req(3, OP_ADD, 16'd200, 16'd2, 1'b0);
        exp_grant.push_back(1);
        push_rsp(1, 101, 1'b0);
        exp_grant.push_back(3);
        push_rsp(3, 202, 1'b0);
        mid();
        check("rst_ptr_grant", 32'(req_rdy), 32'b0010);
        repeat (6) cycle();

`ifdef ALU_ARB_LOCK_EN
        // Accumulate lock: rr_ptr=0, requester 0 locks for three grants then releases
        edge_step();
        set_req(0, OP_MUL_ACCUM, 16'd2, 16'd3, 1'b1);
        set_req(1, OP_ADD, 16'd4, 16'd4, 1'b0);
        set_req(2, OP_ADD, 16'd5, 16'd5, 1'b0);
        set_req(3, OP_ADD, 16'd6, 16'd6, 1'b0);
        sticky = '1;
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back(0);
            push_rsp(0, 6, 1'b0);
        end
        exp_grant.push_back(1);
        push_rsp(1, 8, 1'b0);
        mid();
        repeat (8) cycle();
        edge_step();
        req_lock[0] = 1'b0;
        mid();
        check("lock_release_grant", 32'(req_rdy), 32'b0001);
        repeat (2) cycle();
        cycle();
        check("lock_after_grant", 32'(req_rdy), 32'b0010);
        edge_step();
        req_vld = '0;
        sticky  = '0;
        mid();
        repeat (3) cycle();
`endif

        repeat (3) cycle();
        check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
